// File: rtl/score_bcd_engine.sv
// ---------------------------------------------------------------------------
// score_bcd_engine
//
// Score path for the game display. Score writes from the peripheral bus are
// captured, and control words (top TAG_BITS all ones) are filtered out. Each
// captured score is converted to packed BCD by a sequential double-dabble
// that handles one bit per clock. The module also keeps a sticky game-over
// flag and builds the channel-0 display word, which flashes DEAD_PATTERN
// while the game is over.
//
// Ports:
//   clk        system clock, rising edge
//   RSTN       asynchronous active-low reset
//   wr_en      single-cycle bus write strobe
//   wr_data    bus write data [WIDTH-1:0]
//   flash      blink phase for the game-over pattern
//   score_hex  last accepted binary score
//   bcd        last completed conversion (packed BCD, 4*DIGITS bits)
//   busy       conversion in progress
//   done       one-cycle pulse when bcd updates
//   overflow   last completed score did not fit in DIGITS digits
//   game_over  sticky game-over flag
//   disp       display word
//
// Handshake: there is no back-pressure. A write is taken on any rising edge
// where wr_en=1. Completion is reported by a single-cycle done pulse, and
// bcd/overflow are valid from that cycle until the next completion.
// ---------------------------------------------------------------------------
module score_bcd_engine #(
  parameter int          WIDTH        = 32,
  parameter int          DIGITS       = 8,
  parameter int          TAG_BITS     = 4,
  parameter logic [31:0] DEAD_PATTERN = 32'hDEADDEAD
) (
  input  logic                  clk,
  input  logic                  RSTN,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  flash,
  output logic [WIDTH-1:0]      score_hex,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  game_over,
  output logic [4*DIGITS-1:0]   disp
);

  localparam int BW  = 4 * DIGITS;
  // The BCD field carries one extra carry digit above DIGITS, followed by
  // the binary field.
  localparam int SRW = 4 * (DIGITS + 1) + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  // DEAD_PATTERN is zero-extended first and then cut down to the display width.
  localparam logic [BW+31:0]   DEAD_EXT = {{BW{1'b0}}, DEAD_PATTERN};
  localparam logic [BW-1:0]    DEAD_W   = DEAD_EXT[BW-1:0];
  localparam logic [BW-1:0]    NINES    = {DIGITS{4'h9}};
  localparam logic [TAG_BITS-1:0] TAG_ONES = {TAG_BITS{1'b1}};

  logic [SRW-1:0] sr;
  logic [SRW-1:0] sr_adj;
  logic [SRW-1:0] sr_next;
  logic           shout;
  logic [CW-1:0]  cnt;
  // A 1 shifted out of the carry digit must still count as overflow.
  // Otherwise a carry digit that wraps back to 0 would hide the overflow.
  logic           ovf_sticky;

  logic           is_all_ones;
  logic           is_tagged;
  logic           go_wr;
  logic           score_wr;
  logic           last_iter;
  logic           final_ovf;

  // Write classification. The all-ones word is also tagged, so the game-over
  // word never reaches the score path.
  always_comb begin
    is_all_ones = &wr_data;
    is_tagged   = (wr_data[WIDTH-1 -: TAG_BITS] == TAG_ONES);
    go_wr       = wr_en && is_all_ones;
    score_wr    = wr_en && !is_tagged;
  end

  // One double-dabble step. Every digit of 5 or more gets 3 added, and then
  // the whole register shifts left by one bit.
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d <= DIGITS; d++) begin
      if (sr_adj[WIDTH + 4*d +: 4] >= 4'd5) begin
        sr_adj[WIDTH + 4*d +: 4] = sr_adj[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
    shout   = sr_adj[SRW-1];
    sr_next = {sr_adj[SRW-2:0], 1'b0};
  end

  always_comb begin
    last_iter = busy && (cnt == CW'(1));
    final_ovf = ovf_sticky || shout || (sr_next[SRW-1 -: 4] != 4'd0);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      score_hex  <= '0;
      bcd        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      game_over  <= 1'b0;
      sr         <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      done <= 1'b0;

      if (busy) begin
        sr         <= sr_next;
        cnt        <= cnt - CW'(1);
        ovf_sticky <= ovf_sticky || shout;
        if (last_iter) begin
          busy <= 1'b0;
          done <= 1'b1;
          if (final_ovf) begin
            overflow <= 1'b1;
            bcd      <= NINES;
          end else begin
            overflow <= 1'b0;
            bcd      <= sr_next[WIDTH +: BW];
          end
        end
      end

      if (go_wr) begin
        game_over <= 1'b1;
      end

      // A score write comes last, so it overrides an in-flight conversion.
      // A completion on this same edge has already been published above.
      if (score_wr) begin
        score_hex  <= wr_data;
        game_over  <= 1'b0;
        sr         <= {{(SRW-WIDTH){1'b0}}, wr_data};
        cnt        <= CW'(WIDTH);
        busy       <= 1'b1;
        ovf_sticky <= 1'b0;
      end
    end
  end

  assign disp = (game_over && flash) ? DEAD_W : bcd;

endmodule
